// File: rtl/ip_arp_lut.sv
// ip_arp_lut: resolves the LPM next-hop IP to a destination MAC through a fully
// associative ARP table. Optional saturating miss counter under ARP_MISS_COUNTER_EN.
module ip_arp_lut #(
    parameter int NUM_QUEUES     = 5,
    parameter int ARP_DEPTH      = 32,
    parameter int ARP_DEPTH_BITS = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [31:0]               next_hop_ip,
    input  logic [NUM_QUEUES-1:0]     lpm_output_port,
    input  logic                      lpm_vld,
    input  logic                      lpm_hit,
    output logic [47:0]               next_hop_mac,
    output logic [NUM_QUEUES-1:0]     output_port,
    output logic                      arp_vld,
    output logic                      arp_hit,
    input  logic [ARP_DEPTH_BITS-1:0] arp_rd_addr,
    input  logic                      arp_rd_req,
    output logic [31:0]               arp_rd_ip,
    output logic [47:0]               arp_rd_mac,
    output logic                      arp_rd_ack,
    input  logic [ARP_DEPTH_BITS-1:0] arp_wr_addr,
    input  logic                      arp_wr_req,
    input  logic [31:0]               arp_wr_ip,
    input  logic [47:0]               arp_wr_mac,
    output logic                      arp_wr_ack,
    output logic [31:0]               arp_miss_count
);

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_WAIT = 2'd1,
        WR_ACK  = 2'd2
    } wr_state_t;

    logic [31:0]               r_entry_ip  [ARP_DEPTH];
    logic [47:0]               r_entry_mac [ARP_DEPTH];

    logic [ARP_DEPTH-1:0]      r_match_s1;
    logic                      r_hit_s1;
    logic                      r_vld_s1;
    logic [NUM_QUEUES-1:0]     r_port_s1;

    logic [47:0]               r_next_hop_mac;
    logic [NUM_QUEUES-1:0]     r_output_port;
    logic                      r_arp_vld;
    logic                      r_arp_hit;

    logic [31:0]               r_rd_ip;
    logic [47:0]               r_rd_mac;
    logic                      r_rd_ack;

    wr_state_t                 r_wr_state;
    logic [ARP_DEPTH_BITS-1:0] r_wr_addr;
    logic [31:0]               r_wr_ip;
    logic [47:0]               r_wr_mac;
    logic                      r_wr_ack;

    logic [ARP_DEPTH-1:0]      w_match;
    logic [ARP_DEPTH_BITS-1:0] w_idx;
    logic                      w_any;
    logic [47:0]               w_sel_mac;
    logic                      w_commit;
    logic [ARP_DEPTH_BITS-1:0] w_commit_addr;
    logic [31:0]               w_commit_ip;
    logic [47:0]               w_commit_mac;

    // Compare the incoming next hop against every entry; IP 0 marks an empty slot.
    always_comb begin
        w_match = '0;
        for (int i = 0; i < ARP_DEPTH; i++) begin
            w_match[i] = (r_entry_ip[i] == next_hop_ip) && (r_entry_ip[i] != 32'd0);
        end
    end

    // Lowest matching index wins, so duplicate IPs resolve deterministically.
    always_comb begin
        w_idx = '0;
        w_any = |r_match_s1;
        for (int i = ARP_DEPTH - 1; i >= 0; i--) begin
            w_idx = r_match_s1[i] ? ARP_DEPTH_BITS'(i) : w_idx;
        end
        w_sel_mac = (r_hit_s1 && w_any) ? r_entry_mac[w_idx] : 48'd0;
    end

    // Table writes only land in cycles with no lookup capture, so an in-flight
    // lookup reads a MAC from the same table image it matched against.
    always_comb begin
        w_commit      = 1'b0;
        w_commit_addr = r_wr_addr;
        w_commit_ip   = r_wr_ip;
        w_commit_mac  = r_wr_mac;
        case (r_wr_state)
            WR_IDLE: begin
                w_commit      = arp_wr_req && !lpm_vld;
                w_commit_addr = arp_wr_addr;
                w_commit_ip   = arp_wr_ip;
                w_commit_mac  = arp_wr_mac;
            end
            WR_WAIT: begin
                w_commit = !lpm_vld;
            end
            default: begin
                w_commit = 1'b0;
            end
        endcase
    end

    // ARP table storage.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < ARP_DEPTH; i++) begin
                r_entry_ip[i]  <= 32'd0;
                r_entry_mac[i] <= 48'd0;
            end
        end else if (w_commit) begin
            r_entry_ip[w_commit_addr]  <= w_commit_ip;
            r_entry_mac[w_commit_addr] <= w_commit_mac;
        end
    end

    // Write handshake FSM with registered acknowledge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_state <= WR_IDLE;
            r_wr_addr  <= '0;
            r_wr_ip    <= 32'd0;
            r_wr_mac   <= 48'd0;
            r_wr_ack   <= 1'b0;
        end else begin
            r_wr_ack <= 1'b0;
            case (r_wr_state)
                WR_IDLE: begin
                    if (arp_wr_req) begin
                        r_wr_addr  <= arp_wr_addr;
                        r_wr_ip    <= arp_wr_ip;
                        r_wr_mac   <= arp_wr_mac;
                        r_wr_state <= lpm_vld ? WR_WAIT : WR_ACK;
                    end
                end
                WR_WAIT: begin
                    if (!lpm_vld) begin
                        r_wr_state <= WR_ACK;
                    end
                end
                WR_ACK: begin
                    r_wr_ack   <= 1'b1;
                    r_wr_state <= WR_IDLE;
                end
                default: begin
                    r_wr_state <= WR_IDLE;
                end
            endcase
        end
    end

    // Lookup stage 1: capture match vector and sideband.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_match_s1 <= '0;
            r_hit_s1   <= 1'b0;
            r_vld_s1   <= 1'b0;
            r_port_s1  <= '0;
        end else begin
            r_vld_s1 <= lpm_vld;
            if (lpm_vld) begin
                r_match_s1 <= w_match;
                r_hit_s1   <= lpm_hit;
                r_port_s1  <= lpm_output_port;
            end
        end
    end

    // Lookup stage 2: result registers hold between strobes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_next_hop_mac <= 48'd0;
            r_output_port  <= '0;
            r_arp_vld      <= 1'b0;
            r_arp_hit      <= 1'b0;
        end else begin
            r_arp_vld <= r_vld_s1;
            if (r_vld_s1) begin
                r_next_hop_mac <= w_sel_mac;
                r_output_port  <= r_port_s1;
                r_arp_hit      <= r_hit_s1 && w_any;
            end
        end
    end

    // Register read port; same-cycle writes are not visible yet.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_ip  <= 32'd0;
            r_rd_mac <= 48'd0;
            r_rd_ack <= 1'b0;
        end else begin
            r_rd_ack <= arp_rd_req;
            if (arp_rd_req) begin
                r_rd_ip  <= r_entry_ip[arp_rd_addr];
                r_rd_mac <= r_entry_mac[arp_rd_addr];
            end
        end
    end

`ifdef ARP_MISS_COUNTER_EN
    logic [31:0] r_miss_count;

    // Count routed lookups that found no ARP entry, saturating at all-ones.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_miss_count <= 32'd0;
        end else if (r_vld_s1 && r_hit_s1 && !w_any && (r_miss_count != 32'hFFFF_FFFF)) begin
            r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign arp_miss_count = r_miss_count;
`else
    assign arp_miss_count = 32'd0;
`endif

    assign next_hop_mac = r_next_hop_mac;
    assign output_port  = r_output_port;
    assign arp_vld      = r_arp_vld;
    assign arp_hit      = r_arp_hit;
    assign arp_rd_ip    = r_rd_ip;
    assign arp_rd_mac   = r_rd_mac;
    assign arp_rd_ack   = r_rd_ack;
    assign arp_wr_ack   = r_wr_ack;

endmodule

// File: tb/tb_ip_arp_lut.sv
// Scoreboard bench for ip_arp_lut: stimulus pushes expected results, a negedge
// monitor pops and compares whenever arp_vld, arp_rd_ack or arp_wr_ack pulses.
module tb_ip_arp_lut;
    localparam int NQ = 5;
    localparam int AB = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   next_hop_ip;
    logic [NQ-1:0] lpm_output_port;
    logic          lpm_vld;
    logic          lpm_hit;
    logic [47:0]   next_hop_mac;
    logic [NQ-1:0] output_port;
    logic          arp_vld;
    logic          arp_hit;
    logic [AB-1:0] arp_rd_addr;
    logic          arp_rd_req;
    logic [31:0]   arp_rd_ip;
    logic [47:0]   arp_rd_mac;
    logic          arp_rd_ack;
    logic [AB-1:0] arp_wr_addr;
    logic          arp_wr_req;
    logic [31:0]   arp_wr_ip;
    logic [47:0]   arp_wr_mac;
    logic          arp_wr_ack;
    logic [31:0]   arp_miss_count;

    ip_arp_lut #(.NUM_QUEUES(NQ), .ARP_DEPTH(32), .ARP_DEPTH_BITS(AB)) dut (
        .clk(clk), .reset(reset),
        .next_hop_ip(next_hop_ip), .lpm_output_port(lpm_output_port),
        .lpm_vld(lpm_vld), .lpm_hit(lpm_hit),
        .next_hop_mac(next_hop_mac), .output_port(output_port),
        .arp_vld(arp_vld), .arp_hit(arp_hit),
        .arp_rd_addr(arp_rd_addr), .arp_rd_req(arp_rd_req),
        .arp_rd_ip(arp_rd_ip), .arp_rd_mac(arp_rd_mac), .arp_rd_ack(arp_rd_ack),
        .arp_wr_addr(arp_wr_addr), .arp_wr_req(arp_wr_req),
        .arp_wr_ip(arp_wr_ip), .arp_wr_mac(arp_wr_mac), .arp_wr_ack(arp_wr_ack),
        .arp_miss_count(arp_miss_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [47:0]   mac;
        logic [NQ-1:0] port;
        logic          hit;
        int            due;
    } lk_exp_t;

    typedef struct {
        logic [31:0] ip;
        logic [47:0] mac;
        int          due;
    } rd_exp_t;

    lk_exp_t lk_q[$];
    rd_exp_t rd_q[$];
    int      wr_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // A lookup driven in cycle c is sampled at the next edge and reported two edges later.
    task automatic lookup(input logic [31:0] ip, input logic [NQ-1:0] port, input logic hit,
                          input logic [47:0] emac, input logic ehit);
        lk_exp_t e;
        lpm_vld         = 1'b1;
        next_hop_ip     = ip;
        lpm_output_port = port;
        lpm_hit         = hit;
        e.mac  = emac;
        e.port = port;
        e.hit  = ehit;
        e.due  = cyc + 2;
        lk_q.push_back(e);
    endtask

    task automatic read_req(input logic [AB-1:0] addr, input logic [31:0] eip, input logic [47:0] emac);
        rd_exp_t e;
        arp_rd_req  = 1'b1;
        arp_rd_addr = addr;
        e.ip  = eip;
        e.mac = emac;
        e.due = cyc + 1;
        rd_q.push_back(e);
    endtask

    task automatic write_req(input logic [AB-1:0] addr, input logic [31:0] ip, input logic [47:0] mac);
        arp_wr_req  = 1'b1;
        arp_wr_addr = addr;
        arp_wr_ip   = ip;
        arp_wr_mac  = mac;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mac"},    64'(next_hop_mac),   64'd0);
        check({tag, "_port"},   64'(output_port),    64'd0);
        check({tag, "_vld"},    64'(arp_vld),        64'd0);
        check({tag, "_hit"},    64'(arp_hit),        64'd0);
        check({tag, "_rd_ip"},  64'(arp_rd_ip),      64'd0);
        check({tag, "_rd_mac"}, 64'(arp_rd_mac),     64'd0);
        check({tag, "_rd_ack"}, 64'(arp_rd_ack),     64'd0);
        check({tag, "_wr_ack"}, 64'(arp_wr_ack),     64'd0);
        check({tag, "_miss"},   64'(arp_miss_count), 64'd0);
    endtask

    // Monitor: every result strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (arp_vld === 1'b1) begin
            if (lk_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL lk_unexpected: arp_vld=1 at cycle %0d, expected no result", cyc);
            end else begin
                lk_exp_t e;
                e = lk_q.pop_front();
                check("lk_latency", 64'(cyc),          64'(e.due));
                check("lk_mac",     64'(next_hop_mac), 64'(e.mac));
                check("lk_port",    64'(output_port),  64'(e.port));
                check("lk_hit",     64'(arp_hit),      64'(e.hit));
            end
        end
        if (arp_rd_ack === 1'b1) begin
            if (rd_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL rd_unexpected: arp_rd_ack=1 at cycle %0d, expected no ack", cyc);
            end else begin
                rd_exp_t r;
                r = rd_q.pop_front();
                check("rd_latency", 64'(cyc),        64'(r.due));
                check("rd_ip",      64'(arp_rd_ip),  64'(r.ip));
                check("rd_mac",     64'(arp_rd_mac), 64'(r.mac));
            end
        end
        if (arp_wr_ack === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL wr_unexpected: arp_wr_ack=1 at cycle %0d, expected no ack", cyc);
            end else begin
                int d;
                d = wr_q.pop_front();
                check("wr_ack_latency", 64'(cyc), 64'(d));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_miss;

        reset           = 1'b0;
        next_hop_ip     = 32'h0A00_0001;
        lpm_output_port = 5'b00001;
        lpm_vld         = 1'b1;
        lpm_hit         = 1'b1;
        arp_rd_addr     = 5'd0;
        arp_rd_req      = 1'b0;
        arp_wr_addr     = 5'd0;
        arp_wr_req      = 1'b0;
        arp_wr_ip       = 32'd0;
        arp_wr_mac      = 48'd0;
        tick(3);
        @(negedge clk);
        check_all_zero("reset");

        // Release reset; IP 0 never matches the empty table.
        @(posedge clk);
        #1;
        reset = 1'b1;
        lookup(32'h0000_0000, 5'b00001, 1'b1, 48'd0, 1'b0);
        tick(1);
        lpm_vld = 1'b0;
        tick(3);

        write_req(5'd3, 32'h0A00_0001, 48'h0011_2233_4455);
        wr_q.push_back(cyc + 2);
        tick(1);
        arp_wr_req = 1'b0;
        tick(3);
        lookup(32'h0A00_0001, 5'b00100, 1'b1, 48'h0011_2233_4455, 1'b1);
        tick(1);
        lpm_vld = 1'b0;
        tick(1);

        // Duplicate IP in entries 7 and 2: entry 2 must win.
        write_req(5'd7, 32'hC0A8_0001, 48'hAAAA_0000_0007);
        wr_q.push_back(cyc + 2);
        tick(1);
        arp_wr_req = 1'b0;
        tick(2);
        write_req(5'd2, 32'hC0A8_0001, 48'hBBBB_0000_0002);
        wr_q.push_back(cyc + 2);
        tick(1);
        arp_wr_req = 1'b0;
        tick(2);
        lookup(32'hC0A8_0001, 5'b00010, 1'b1, 48'hBBBB_0000_0002, 1'b1);
        tick(1);
        lookup(32'hC0A8_0001, 5'b01000, 1'b0, 48'd0, 1'b0);
        tick(1);
        lookup(32'h0102_0304, 5'b10000, 1'b1, 48'd0, 1'b0);
        tick(1);
        lpm_vld = 1'b0;
        tick(3);

        // Ten back-to-back lookups while a write waits; all see the old table.
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                lookup(32'h0A00_0001, 5'(1 << (i % 5)), 1'b1, 48'h0011_2233_4455, 1'b1);
            end else begin
                lookup(32'h0B00_0005, 5'(1 << (i % 5)), 1'b1, 48'd0, 1'b0);
            end
            if (i == 0) begin
                write_req(5'd5, 32'h0B00_0005, 48'h5555_5555_5555);
            end else begin
                arp_wr_req = 1'b0;
            end
            tick(1);
        end
        lpm_vld = 1'b0;
        wr_q.push_back(cyc + 2);
        tick(3);
        lookup(32'h0B00_0005, 5'b10000, 1'b1, 48'h5555_5555_5555, 1'b1);
        tick(1);
        lpm_vld = 1'b0;
        tick(3);

        read_req(5'd3, 32'h0A00_0001, 48'h0011_2233_4455);
        tick(1);
        arp_rd_req = 1'b0;
        tick(1);
        // Read and write of entry 9 in the same cycle returns the old contents.
        read_req(5'd9, 32'd0, 48'd0);
        write_req(5'd9, 32'h0C00_0009, 48'h9999_9999_9999);
        wr_q.push_back(cyc + 2);
        tick(1);
        arp_rd_req = 1'b0;
        arp_wr_req = 1'b0;
        tick(2);
        read_req(5'd9, 32'h0C00_0009, 48'h9999_9999_9999);
        tick(1);
        arp_rd_req = 1'b0;
        tick(2);

        // Misses so far with a routed lookup: release lookup, 0102_0304, five in the burst.
`ifdef ARP_MISS_COUNTER_EN
        exp_miss = 32'd7;
`else
        exp_miss = 32'd0;
`endif
        @(negedge clk);
        check("miss_count_mid", 64'(arp_miss_count), 64'(exp_miss));

        // Lookup in flight when reset asserts is discarded.
        @(posedge clk);
        #1;
        lpm_vld         = 1'b1;
        next_hop_ip     = 32'h0A00_0001;
        lpm_output_port = 5'b00001;
        lpm_hit         = 1'b1;
        tick(1);
        lpm_vld = 1'b0;
        reset   = 1'b0;
        tick(2);
        @(negedge clk);
        check_all_zero("inflight_reset");
        @(posedge clk);
        #1;
        reset = 1'b1;
        tick(2);

        // Table was cleared: former entries now miss.
        lookup(32'h0A00_0001, 5'b00001, 1'b1, 48'd0, 1'b0);
        tick(1);
        lookup(32'h0B00_0005, 5'b00010, 1'b1, 48'd0, 1'b0);
        tick(1);
        lookup(32'h0102_0304, 5'b00100, 1'b0, 48'd0, 1'b0);
        tick(1);
        lookup(32'h0C00_0009, 5'b01000, 1'b1, 48'd0, 1'b0);
        tick(1);
        lpm_vld = 1'b0;
        tick(3);
`ifdef ARP_MISS_COUNTER_EN
        exp_miss = 32'd3;
`else
        exp_miss = 32'd0;
`endif
        @(negedge clk);
        check("miss_count_after", 64'(arp_miss_count), 64'(exp_miss));

`ifdef ARP_MISS_COUNTER_EN
        @(posedge clk);
        #1;
        force dut.r_miss_count = 32'hFFFF_FFFF;
        tick(1);
        release dut.r_miss_count;
        lookup(32'h0A00_0001, 5'b00001, 1'b1, 48'd0, 1'b0);
        tick(1);
        lpm_vld = 1'b0;
        tick(3);
        @(negedge clk);
        check("miss_count_sat", 64'(arp_miss_count), 64'h0000_0000_FFFF_FFFF);
`endif

        tick(4);
        check("lk_outstanding", 64'(lk_q.size()), 64'd0);
        check("rd_outstanding", 64'(rd_q.size()), 64'd0);
        check("wr_outstanding", 64'(wr_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
